// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM arbiter between the CPU and the video line fetcher.
package sdram_pkg;

  localparam int BURST_LEN = 32;
  localparam int FIRST_LAT = 4;
  localparam int WDOG_MAX  = 255;
  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 16;

  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int CNT_W  = $clog2(FIRST_LAT + BURST_LEN + 1);
  localparam int WDOG_W = $clog2(WDOG_MAX + 1);

  // Beat counter value of the first video word and the saturation value after the last one.
  localparam logic [CNT_W-1:0] BEAT_FIRST = CNT_W'(FIRST_LAT);
  localparam logic [CNT_W-1:0] BEAT_END   = CNT_W'(FIRST_LAT + BURST_LEN);

  localparam logic [DATA_W-1:0] WDOG_RDATA = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_DONE,
    ST_STREAM,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/sdram_arb_prio.sv
// Grant select: video normally wins a tie, but never twice in a row while the CPU waits.
module sdram_arb_prio (
  input  logic cpu_req,
  input  logic vid_req,
  input  logic last_vid,
  output logic grant_cpu,
  output logic grant_vid
);

  assign grant_vid = vid_req && (!cpu_req || !last_vid);
  assign grant_cpu = cpu_req && !grant_vid;

endmodule

// File: rtl/sdram_arb.sv
// Two-port SDRAM arbiter (CPU single word, video 32-word burst) driving one controller.
// Optional watchdog: define SDRAM_ARB_WDOG_EN to add wdog_err and the stuck-state timeout.
module sdram_arb
  import sdram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic [IDX_W-1:0]  vid_idx,
  output logic              ctl_start,
  output logic              ctl_write_en,
  output logic              ctl_burst_en,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_data_in,
  input  logic              ctl_mem_ready,
  input  logic              ctl_data_ready,
  input  logic [DATA_W-1:0] ctl_data_out
`ifdef SDRAM_ARB_WDOG_EN
  ,
  output logic              wdog_err
`endif
);

  state_e           r_state, w_next;
  logic             r_last_vid, r_is_vid;
  logic [CNT_W-1:0] r_cnt;
  logic             w_grant_cpu, w_grant_vid, w_grant, w_wdog_to;

  sdram_arb_prio u_prio (
    .cpu_req   (cpu_req),
    .vid_req   (vid_req),
    .last_vid  (r_last_vid),
    .grant_cpu (w_grant_cpu),
    .grant_vid (w_grant_vid)
  );

  assign w_grant = (r_state == ST_IDLE) && ctl_data_ready && (w_grant_cpu || w_grant_vid);

`ifdef SDRAM_ARB_WDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              w_watched;

  assign w_watched = !(r_state inside {ST_INIT, ST_IDLE});
  assign w_wdog_to = w_watched && (r_wdog == WDOG_W'(WDOG_MAX));

  // Counts cycles spent in the current busy state; any state change restarts it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdog   <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (w_wdog_to) wdog_err <= 1'b1;
      r_wdog <= (w_watched && (w_next == r_state)) ? r_wdog + 1'b1 : '0;
    end
  end
`else
  assign w_wdog_to = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:      if (ctl_mem_ready) w_next = ST_IDLE;
      ST_IDLE:      if (w_grant) w_next = ST_ISSUE;
      ST_ISSUE:     w_next = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!ctl_data_ready) w_next = r_is_vid ? ST_STREAM : ST_WAIT_DONE;
      ST_WAIT_DONE: if (ctl_data_ready) w_next = ST_FINISH;
      ST_STREAM:    if ((r_cnt == BEAT_END) && ctl_data_ready) w_next = ST_IDLE;
      ST_FINISH:    w_next = ST_IDLE;
      default:      w_next = ST_INIT;
    endcase
    if (w_wdog_to) w_next = r_is_vid ? ST_IDLE : ST_FINISH;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_last_vid   <= 1'b0;
      r_is_vid     <= 1'b0;
      r_cnt        <= '0;
      ctl_addr     <= '0;
      ctl_data_in  <= '0;
      ctl_write_en <= 1'b0;
      ctl_burst_en <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      r_state <= w_next;
      // Command fields are loaded only at grant, so they hold until the next grant.
      if (w_grant) begin
        ctl_addr     <= w_grant_vid ? vid_addr : cpu_addr;
        ctl_data_in  <= w_grant_vid ? '0 : cpu_wdata;
        ctl_write_en <= w_grant_cpu && cpu_we;
        ctl_burst_en <= w_grant_vid;
        r_is_vid     <= w_grant_vid;
        r_last_vid   <= w_grant_vid;
        r_cnt        <= '0;
      end else if (r_cnt != BEAT_END) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == ST_WAIT_DONE) && ctl_data_ready && !ctl_write_en) cpu_rdata <= ctl_data_out;
      if (w_wdog_to && !r_is_vid) cpu_rdata <= WDOG_RDATA;
    end
  end

  assign ctl_start = (r_state == ST_ISSUE);
  assign vid_ack   = (r_state == ST_ISSUE) && r_is_vid;
  assign cpu_done  = (r_state == ST_FINISH);
  assign vid_valid = (r_state == ST_STREAM) && (r_cnt >= BEAT_FIRST) && (r_cnt < BEAT_END);
  assign vid_data  = vid_valid ? ctl_data_out : '0;
  assign vid_idx   = vid_valid ? IDX_W'(r_cnt - BEAT_FIRST) : '0;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed self-checking bench for sdram_arb with a cycle-counting SDRAM controller model.
module tb_sdram_arb;
  import sdram_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr, vid_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_done, vid_req, vid_ack, vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic [IDX_W-1:0]  vid_idx;
  logic              ctl_start, ctl_write_en, ctl_burst_en;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_data_in, ctl_data_out;
  logic              ctl_mem_ready, ctl_data_ready;
`ifdef SDRAM_ARB_WDOG_EN
  logic              wdog_err;
`endif

  sdram_arb dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_done       (cpu_done),
    .vid_req        (vid_req),
    .vid_addr       (vid_addr),
    .vid_ack        (vid_ack),
    .vid_valid      (vid_valid),
    .vid_data       (vid_data),
    .vid_idx        (vid_idx),
    .ctl_start      (ctl_start),
    .ctl_write_en   (ctl_write_en),
    .ctl_burst_en   (ctl_burst_en),
    .ctl_addr       (ctl_addr),
    .ctl_data_in    (ctl_data_in),
    .ctl_mem_ready  (ctl_mem_ready),
    .ctl_data_ready (ctl_data_ready),
    .ctl_data_out   (ctl_data_out)
`ifdef SDRAM_ARB_WDOG_EN
    ,
    .wdog_err       (wdog_err)
`endif
  );

  always #5 clk = ~clk;

  // Controller model: k counts cycles since the start pulse (k=0 in the start cycle).
  // Ready drops after start and returns at k=5 (single) or k=36 (burst); burst word at k is A000+k.
  logic              m_hang;
  logic [DATA_W-1:0] m_rdata;
  int                k = 1000;
  always begin
    @(posedge clk);
    #1;
    if (ctl_start) k = 0;
    else if (k < 1000) k++;
    ctl_data_out = ctl_burst_en ? 16'(32'hA000 + k) : m_rdata;
    if (k == 0)      ctl_data_ready = 1'b1;
    else if (m_hang) ctl_data_ready = 1'b0;
    else             ctl_data_ready = (k >= (ctl_burst_en ? 36 : 5));
  end

  // Event monitor sampled on the falling edge.
  int         cyc = 0, n_start = 0, n_done = 0, n_ack = 0, n_valid = 0;
  int         idx_err = 0, gap_err = 0, overlap = 0;
  int         beat = 0, t_ack = 0, last_v = 0, first_off = -1, last_idx = -1;
  logic [2:0] grants = '0;
  always @(negedge clk) begin
    cyc++;
    if (ctl_start) begin
      n_start++;
      grants = {grants[1:0], ctl_burst_en};
    end
    if (cpu_done) n_done++;
    if (cpu_done && vid_ack) overlap++;
    if (vid_ack) begin
      n_ack++;
      t_ack = cyc;
      beat  = 0;
    end
    if (vid_valid) begin
      n_valid++;
      if (vid_idx != IDX_W'(beat) || vid_data != 16'(32'hA000 + beat + FIRST_LAT)) idx_err++;
      if (beat == 0) first_off = cyc - t_ack;
      else if (cyc != last_v + 1) gap_err++;
      last_v   = cyc;
      last_idx = int'(vid_idx);
      beat++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // which: 0 ctl_start, 1 cpu_done, 2 vid_ack. Returns at the falling edge where it is seen.
  task automatic wait_sig(input int which, input int lim, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      tick();
      case (which)
        0:       hit = ctl_start;
        1:       hit = cpu_done;
        default: hit = vid_ack;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  int s0, d0, a0, v0, ie0, g0, o0, nv;
  logic found;

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0; ctl_mem_ready = 1'b0; m_hang = 1'b0; m_rdata = '0;
    repeat (3) tick();
    check("rst_ctl_start", 32'(ctl_start), 0);
    check("rst_cpu_done",  32'(cpu_done), 0);
    check("rst_vid_ack",   32'(vid_ack), 0);
    check("rst_vid_valid", 32'(vid_valid), 0);
    check("rst_ctl_addr",  32'(ctl_addr), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);

    // No grant while the controller is still initialising; a dropped request is forgotten.
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 25'h0000777;
    repeat (6) tick();
    check("no_grant_before_mem_ready", n_start, 0);
    cpu_req = 1'b0;
    tick();
    ctl_mem_ready = 1'b1;
    repeat (6) tick();
    check("dropped_req_ignored", n_start, 0);

    // CPU write.
    s0 = n_start; d0 = n_done;
    cpu_we = 1'b1; cpu_addr = 25'h0000123; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
    wait_sig(0, 20, "wr_start_seen");
    check("wr_write_en", 32'(ctl_write_en), 1);
    check("wr_burst_en", 32'(ctl_burst_en), 0);
    check("wr_addr",     32'(ctl_addr), 32'h123);
    check("wr_data_in",  32'(ctl_data_in), 32'hBEEF);
    wait_sig(1, 20, "wr_done_seen");
    cpu_req = 1'b0;
    check("wr_addr_held", 32'(ctl_addr), 32'h123);
    check("wr_we_held",   32'(ctl_write_en), 1);
    repeat (3) tick();
    check("wr_start_once", n_start - s0, 1);
    check("wr_done_once",  n_done - d0, 1);

    // Video burst.
    s0 = n_start; a0 = n_ack; v0 = n_valid; ie0 = idx_err; g0 = gap_err;
    vid_addr = 25'h0010000; vid_req = 1'b1;
    wait_sig(2, 20, "vid_ack_seen");
    vid_req = 1'b0;
    check("vid_burst_en", 32'(ctl_burst_en), 1);
    check("vid_write_en", 32'(ctl_write_en), 0);
    check("vid_addr",     32'(ctl_addr), 32'h0010000);
    repeat (45) tick();
    check("vid_ack_once",    n_ack - a0, 1);
    check("vid_start_once",  n_start - s0, 1);
    check("vid_valid_count", n_valid - v0, BURST_LEN);
    check("vid_idx_data",    idx_err - ie0, 0);
    check("vid_consecutive", gap_err - g0, 0);
    check("vid_first_off",   first_off, FIRST_LAT);
    check("vid_last_idx",    last_idx, BURST_LEN - 1);

    // CPU read.
    m_rdata = 16'hBEEF; cpu_we = 1'b0; cpu_wdata = 16'h0000; cpu_req = 1'b1;
    wait_sig(0, 20, "rd_start_seen");
    check("rd_write_en", 32'(ctl_write_en), 0);
    wait_sig(1, 20, "rd_done_seen");
    check("rd_data", 32'(cpu_rdata), 32'hBEEF);
    cpu_req = 1'b0;
    repeat (2) tick();

    // Both raised together after a CPU grant: video, CPU, video.
    s0 = n_start; d0 = n_done; v0 = n_valid; o0 = overlap; nv = 0;
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int i = 0; i < 300 && nv < 2; i++) begin
      tick();
      if (cpu_done) cpu_req = 1'b0;
      if (vid_ack) begin
        nv++;
        if (nv == 2) vid_req = 1'b0;
      end
    end
    check("both_two_vid_grants", nv, 2);
    repeat (45) tick();
    check("both_order_vcv",   32'(grants), 32'b101);
    check("both_start_count", n_start - s0, 3);
    check("both_done_count",  n_done - d0, 1);
    check("both_valid_count", n_valid - v0, 2 * BURST_LEN);
    check("both_no_overlap",  overlap - o0, 0);

    // Reset in the middle of a burst at word 10.
    vid_addr = 25'h0020000; vid_req = 1'b1;
    wait_sig(2, 20, "rst_vid_ack_seen");
    vid_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = vid_valid && (vid_idx == 5'd10);
    end
    check("rst_word10_reached", 32'(found), 1);
    rst = 1'b0; ctl_mem_ready = 1'b0;
    tick();
    check("mid_rst_vid_valid", 32'(vid_valid), 0);
    check("mid_rst_vid_idx",   32'(vid_idx), 0);
    check("mid_rst_vid_data",  32'(vid_data), 0);
    check("mid_rst_ctl_addr",  32'(ctl_addr), 0);
    check("mid_rst_burst_en",  32'(ctl_burst_en), 0);
    check("mid_rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("mid_rst_ctl_start", 32'(ctl_start), 0);
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; s0 = n_start;
    repeat (8) tick();
    check("mid_rst_no_grant", n_start - s0, 0);
    ctl_mem_ready = 1'b1;
    wait_sig(1, 30, "mid_rst_recover_done");
    cpu_req = 1'b0;
    check("mid_rst_recover_start", n_start - s0, 1);

`ifdef SDRAM_ARB_WDOG_EN
    // Controller never completes: the watchdog must end the CPU transaction.
    repeat (2) tick();
    m_hang = 1'b1; cpu_req = 1'b1;
    wait_sig(0, 20, "wdog_start_seen");
    repeat (200) tick();
    check("wdog_not_early", 32'(wdog_err), 0);
    wait_sig(1, 100, "wdog_done_seen");
    check("wdog_err_set", 32'(wdog_err), 1);
    check("wdog_rdata",   32'(cpu_rdata), 32'hDEAD);
    cpu_req = 1'b0; m_hang = 1'b0;
    repeat (3) tick();
    check("wdog_err_sticky", 32'(wdog_err), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
